// File: rtl/pipelined_memory_interface.sv
// rtl/pipelined_memory_interface.sv - pipelined load/store data memory interface
//
// Word-organised data memory behind a valid/ready request port with a fixed
// LATENCY-stage response pipeline, byte/half/word lanes, sign-extending loads,
// misalignment and out-of-bounds detection and an optional post-reset clear.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_req_valid       request present; accepted when o_req_ready is high
//   o_req_ready       high in RUN, low during reset and the clear sequence
//   i_req_addr        byte address
//   i_req_wr_data     store data, right-aligned
//   i_req_count       access size (NONE/BYTE/HALF/WORD)
//   i_req_wr_en       1 = store, 0 = load
//   i_req_signed      loads: 1 = sign-extend, 0 = zero-extend
//   o_res_valid       one-cycle pulse per accepted request, LATENCY cycles later
//   o_res_rd_data     load data (0 when not a successful load or not valid)
//   o_res_code        response code (NONE when not valid)
//   o_busy            clear sequence in progress

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_NONE 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OOB 3'd4
`endif

module pipelined_memory_interface #(
   parameter int WORD_COUNT     = 128,
   parameter int LATENCY        = 1,
   parameter bit CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [`ADDR_W-1:0]      i_req_addr,
   input  logic [`WORD_W-1:0]      i_req_wr_data,
   input  logic [`MEM_COUNT_W-1:0] i_req_count,
   input  logic                    i_req_wr_en,
   input  logic                    i_req_signed,
   output logic                    o_res_valid,
   output logic [`WORD_W-1:0]      o_res_rd_data,
   output logic [`MEM_CODE_W-1:0]  o_res_code,
   output logic                    o_busy
);

   localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam int WIDX_W = `ADDR_W - 2;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                                state_q, state_d;
   logic [IDX_W-1:0]                      clr_idx_q, clr_idx_d;
   logic                                  busy_q, busy_d;
   logic                                  ready_q, ready_d;
   logic [LATENCY-1:0]                    pv_q, pv_d;
   logic [LATENCY-1:0][`WORD_W-1:0]       pd_q, pd_d;
   logic [LATENCY-1:0][`MEM_CODE_W-1:0]   pc_q, pc_d;

   logic [`WORD_W-1:0] r_mem [WORD_COUNT];

   logic                   accept, misaligned, oob, do_store, clear_we;
   logic [IDX_W-1:0]       word_idx;
   logic [3:0]             lane_be;
   logic [`WORD_W-1:0]     lane_wdata, rd_word, rd_shift, rd_ext, res_data;
   logic [`MEM_CODE_W-1:0] res_code;

   // Reset gates acceptance directly so a request on the reset edge never writes.
   assign accept   = i_req_valid & ready_q & ~reset;
   assign word_idx = i_req_addr[IDX_W+1:2];
   assign oob      = i_req_addr[`ADDR_W-1:2] >= WIDX_W'(WORD_COUNT);
   // Clearing only runs once busy is visible, so o_busy spans exactly the writes.
   assign clear_we = (state_q == S_CLEAR) & busy_q & ~reset;
   assign rd_word  = r_mem[word_idx];
   assign rd_shift = rd_word >> {i_req_addr[1:0], 3'b000};

   always_comb begin
      misaligned = 1'b0;
      lane_be    = 4'b0000;
      lane_wdata = '0;
      rd_ext     = rd_shift;
      case (i_req_count)
         `MEM_COUNT_BYTE: begin
            lane_be    = 4'b0001 << i_req_addr[1:0];
            lane_wdata = {4{i_req_wr_data[7:0]}};
            rd_ext     = {{24{i_req_signed & rd_shift[7]}}, rd_shift[7:0]};
         end
         `MEM_COUNT_HALF: begin
            misaligned = i_req_addr[0];
            lane_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{i_req_wr_data[15:0]}};
            rd_ext     = {{16{i_req_signed & rd_shift[15]}}, rd_shift[15:0]};
         end
         `MEM_COUNT_WORD: begin
            misaligned = |i_req_addr[1:0];
            lane_be    = 4'b1111;
            lane_wdata = i_req_wr_data;
         end
         default: ;
      endcase
   end

   // Classification priority: NONE, misaligned, out of bounds, store, load.
   always_comb begin
      res_code = `MEM_CODE_NONE;
      res_data = '0;
      do_store = 1'b0;
      if (i_req_count == `MEM_COUNT_NONE) begin
         res_code = `MEM_CODE_NONE;
      end else if (misaligned) begin
         res_code = `MEM_CODE_MISALIGNED;
      end else if (oob) begin
         res_code = `MEM_CODE_OOB;
      end else if (i_req_wr_en) begin
         res_code = `MEM_CODE_WRITE;
         do_store = accept;
      end else begin
         res_code = `MEM_CODE_READ;
         res_data = rd_ext;
      end
   end

   // Memory is not reset; stores land on the acceptance edge so the next load sees them.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         r_mem[clr_idx_q] <= '0;
      end else if (do_store) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_be[b]) r_mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      busy_d    = 1'b0;
      ready_d   = 1'b0;
      case (state_q)
         S_CLEAR: begin
            busy_d = 1'b1;
            if (busy_q) begin
               if (clr_idx_q == IDX_W'(WORD_COUNT - 1)) begin
                  state_d = S_RUN;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  clr_idx_d = clr_idx_q + IDX_W'(1);
               end
            end
         end
         S_RUN:   ready_d = 1'b1;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      pv_d    = '0;
      pd_d    = '0;
      pc_d    = '0;
      pv_d[0] = accept;
      pd_d[0] = accept ? res_data : '0;
      pc_d[0] = accept ? res_code : `MEM_CODE_NONE;
      for (int s = 1; s < LATENCY; s++) begin
         pv_d[s] = pv_q[s-1];
         pd_d[s] = pd_q[s-1];
         pc_d[s] = pc_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
         clr_idx_q <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         pv_q      <= '0;
         pd_q      <= '0;
         pc_q      <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         pv_q      <= pv_d;
         pd_q      <= pd_d;
         pc_q      <= pc_d;
      end
   end

   assign o_req_ready   = ready_q;
   assign o_busy        = busy_q;
   assign o_res_valid   = pv_q[LATENCY-1];
   assign o_res_rd_data = pd_q[LATENCY-1];
   assign o_res_code    = pc_q[LATENCY-1];

endmodule

// File: tb/tb_pipelined_memory_interface.sv
// tb/tb_pipelined_memory_interface.sv - randomized model-checked bench for pipelined_memory_interface

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_NONE 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OOB 3'd4
`endif

module tb_pipelined_memory_interface;

   localparam int WC  = 128;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wr_data;
   logic [1:0]  i_req_count;
   logic        i_req_wr_en;
   logic        i_req_signed;
   logic        o_res_valid;
   logic [31:0] o_res_rd_data;
   logic [2:0]  o_res_code;
   logic        o_busy;

   pipelined_memory_interface #(.WORD_COUNT(WC), .LATENCY(LAT), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(i_req_addr), .i_req_wr_data(i_req_wr_data),
      .i_req_count(i_req_count), .i_req_wr_en(i_req_wr_en),
      .i_req_signed(i_req_signed),
      .o_res_valid(o_res_valid), .o_res_rd_data(o_res_rd_data),
      .o_res_code(o_res_code), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] data;
      int          c;
   } resp_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int since_rst = 0;
   int busy_cnt = 0;
   bit started = 0;
   bit exp_ready = 0;
   bit exp_busy = 0;
   logic [7:0] bmem [WC*4];
   resp_t exp_q[$];
   resp_t log_q[$];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Byte-addressed reference: accesses are n consecutive little-endian bytes.
   function automatic void model_access(input logic [31:0] a, input logic [31:0] wd,
                                        input logic [1:0] cnt, input logic wr, input logic sg,
                                        output logic [2:0] code, output logic [31:0] data);
      int n;
      logic [31:0] v, mask;
      data = 0;
      n = (cnt == 2'd1) ? 1 : (cnt == 2'd2) ? 2 : 4;
      if (cnt == 2'd0) code = `MEM_CODE_NONE;
      else if (int'(a % n) != 0) code = `MEM_CODE_MISALIGNED;
      else if ((a >> 2) >= WC) code = `MEM_CODE_OOB;
      else if (wr) begin
         for (int i = 0; i < n; i++) bmem[int'(a) + i] = wd[8*i +: 8];
         code = `MEM_CODE_WRITE;
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[int'(a) + i];
         if (sg && n < 4 && v[8*n-1]) begin
            mask = (32'h1 << (8*n)) - 32'h1;
            v = v | ~mask;
         end
         code = `MEM_CODE_READ;
         data = v;
      end
   endfunction

   // Model: ready/busy timeline counted in edges since reset, responses timestamped.
   always @(posedge clk) begin
      logic [2:0] c;
      logic [31:0] d;
      resp_t r;
      cyc++;
      if (reset) begin
         started = 1;
         since_rst = 0;
         exp_q.delete();
         exp_ready = 0;
         exp_busy = 0;
      end else if (started) begin
         if (exp_ready && i_req_valid) begin
            model_access(i_req_addr, i_req_wr_data, i_req_count, i_req_wr_en, i_req_signed, c, d);
            r.code = c; r.data = d; r.c = cyc + LAT - 1;
            exp_q.push_back(r);
         end
         if (since_rst <= WC) begin
            since_rst++;
            if (since_rst == WC + 1) for (int i = 0; i < WC*4; i++) bmem[i] = 8'h00;
         end
         exp_busy = (since_rst >= 1) && (since_rst <= WC);
         exp_ready = since_rst > WC;
      end
   end

   always @(negedge clk) begin
      resp_t r;
      bit ev;
      if (started) begin
         ev = (exp_q.size() > 0) && (exp_q[0].c == cyc);
         check("req_ready", o_req_ready, exp_ready);
         check("busy", o_busy, exp_busy);
         check("res_valid", o_res_valid, ev);
         if (ev) begin
            check("res_data", o_res_rd_data, exp_q[0].data);
            check("res_code", o_res_code, exp_q[0].code);
            void'(exp_q.pop_front());
         end else begin
            check("idle_data", o_res_rd_data, 0);
            check("idle_code", o_res_code, `MEM_CODE_NONE);
         end
         if (o_res_valid) begin
            r.code = o_res_code; r.data = o_res_rd_data; r.c = cyc;
            log_q.push_back(r);
         end
         if (o_busy) busy_cnt++;
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] cnt,
                      input logic wr, input logic sg);
      i_req_valid = 1; i_req_addr = a; i_req_wr_data = wd;
      i_req_count = cnt; i_req_wr_en = wr; i_req_signed = sg;
      @(posedge clk);
      #1;
      i_req_valid = 0;
   endtask

   // Optionally keeps a store request asserted while waiting; it must be ignored.
   task automatic wait_ready(input bit noise);
      int k = 0;
      i_req_addr = 0; i_req_wr_data = 32'hA5A5A5A5;
      i_req_count = `MEM_COUNT_WORD; i_req_wr_en = 1; i_req_signed = 0;
      while (!exp_ready && k < 400) begin
         i_req_valid = noise;
         cyc_wait(1);
         k++;
      end
      i_req_valid = 0;
      n_cmp++;
      if (!exp_ready) begin
         n_fail++;
         $display("FAIL ready_timeout: ready not reached after %0d cycles", k);
      end
   endtask

   task automatic expect_resp(input string nm, input int i, input logic [2:0] code,
                              input logic [31:0] data);
      if (i < log_q.size()) begin
         check({nm, "_code"}, log_q[i].code, code);
         check({nm, "_data"}, log_q[i].data, data);
      end else begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: response %0d missing, got %0d responses", nm, i, log_q.size());
      end
   endtask

   initial begin
      logic [2:0]  mc;
      logic [31:0] md;
      int t0;
      reset = 1; i_req_valid = 0; i_req_addr = 0; i_req_wr_data = 0;
      i_req_count = 0; i_req_wr_en = 0; i_req_signed = 0;
      cyc_wait(3);
      busy_cnt = 0;
      reset = 0;
      wait_ready(0);
      check("clear_len_first", busy_cnt, 128);

      // Fill memory with nonzero data, then reset twice (second one mid-clear).
      for (int w = 0; w < WC; w++) req(w*4, $urandom | 32'h1, `MEM_COUNT_WORD, 1, 0);
      cyc_wait(LAT + 1);
      reset = 1; cyc_wait(2); reset = 0;
      cyc_wait(51);
      reset = 1; cyc_wait(2); busy_cnt = 0; reset = 0;
      wait_ready(1);
      check("clear_len_restart", busy_cnt, 128);

      log_q.delete();
      for (int w = 0; w < WC; w++) req(w*4, 0, `MEM_COUNT_WORD, 0, 0);
      cyc_wait(LAT + 2);
      expect_resp("clear_word5", 5, `MEM_CODE_READ, 0);
      expect_resp("clear_word127", 127, `MEM_CODE_READ, 0);

      // Misalignment, out of bounds (0x200 aliases word 0 if the check is missing), NONE.
      log_q.delete();
      req(32'h0, 32'h11223344, `MEM_COUNT_WORD, 1, 0);
      req(32'h1, 32'hFFFFFFFF, `MEM_COUNT_WORD, 1, 0);
      req(32'h3, 0, `MEM_COUNT_HALF, 0, 0);
      req(32'h200, 32'hCAFEF00D, `MEM_COUNT_WORD, 1, 0);
      req(32'h0, 0, `MEM_COUNT_WORD, 0, 0);
      req(32'h40, 32'h1234, `MEM_COUNT_NONE, 1, 0);
      cyc_wait(LAT + 2);
      expect_resp("store_ok", 0, `MEM_CODE_WRITE, 0);
      expect_resp("mis_word", 1, `MEM_CODE_MISALIGNED, 0);
      expect_resp("mis_half", 2, `MEM_CODE_MISALIGNED, 0);
      expect_resp("oob_store", 3, `MEM_CODE_OOB, 0);
      expect_resp("unchanged", 4, `MEM_CODE_READ, 32'h11223344);
      expect_resp("count_none", 5, `MEM_CODE_NONE, 0);

      // Lanes and extension.
      log_q.delete();
      req(32'h10, 32'h0, `MEM_COUNT_WORD, 1, 0);
      req(32'h12, 32'hFFFFFF80, `MEM_COUNT_BYTE, 1, 0);
      req(32'h10, 0, `MEM_COUNT_WORD, 0, 0);
      req(32'h12, 0, `MEM_COUNT_BYTE, 0, 1);
      req(32'h12, 0, `MEM_COUNT_BYTE, 0, 0);
      req(32'h16, 32'h1234BEEF, `MEM_COUNT_HALF, 1, 0);
      req(32'h16, 0, `MEM_COUNT_HALF, 0, 1);
      req(32'h14, 0, `MEM_COUNT_WORD, 0, 0);
      cyc_wait(LAT + 2);
      expect_resp("byte_lane_word", 2, `MEM_CODE_READ, 32'h00800000);
      expect_resp("byte_signed", 3, `MEM_CODE_READ, 32'hFFFFFF80);
      expect_resp("byte_unsigned", 4, `MEM_CODE_READ, 32'h00000080);
      expect_resp("half_signed", 6, `MEM_CODE_READ, 32'hFFFFBEEF);
      expect_resp("half_lane_word", 7, `MEM_CODE_READ, 32'hBEEF0000);
      model_access(32'h10, 0, `MEM_COUNT_WORD, 0, 0, mc, md);
      check("model_pin_word", md, 32'h00800000);
      model_access(32'h16, 0, `MEM_COUNT_HALF, 0, 1, mc, md);
      check("model_pin_half", md, 32'hFFFFBEEF);

      // Back-to-back latency and ordering.
      log_q.delete();
      t0 = cyc;
      req(32'h30, 32'h0BADF00D, `MEM_COUNT_WORD, 1, 0);
      req(32'h30, 0, `MEM_COUNT_WORD, 0, 0);
      req(32'h31, 0, `MEM_COUNT_BYTE, 0, 0);
      req(32'h32, 0, `MEM_COUNT_HALF, 0, 1);
      req(32'h33, 0, `MEM_COUNT_WORD, 0, 0);
      cyc_wait(LAT + 2);
      check("lat_count", log_q.size(), 5);
      for (int k = 0; k < 5 && k < log_q.size(); k++) check("lat_cycle", log_q[k].c - t0, 3 + k);
      expect_resp("lat_store", 0, `MEM_CODE_WRITE, 0);
      expect_resp("lat_word", 1, `MEM_CODE_READ, 32'h0BADF00D);
      expect_resp("lat_byte", 2, `MEM_CODE_READ, 32'h000000F0);
      expect_resp("lat_half", 3, `MEM_CODE_READ, 32'h00000BAD);
      expect_resp("lat_mis", 4, `MEM_CODE_MISALIGNED, 0);

      // Store immediately followed by a load of the same word.
      log_q.delete();
      req(32'h20, 32'hDEADBEEF, `MEM_COUNT_WORD, 1, 0);
      req(32'h20, 0, `MEM_COUNT_WORD, 0, 0);
      cyc_wait(LAT + 2);
      expect_resp("forward", 1, `MEM_CODE_READ, 32'hDEADBEEF);

      // Reset with two loads in flight drops both responses.
      req(32'h24, 32'h5555AAAA, `MEM_COUNT_WORD, 1, 0);
      cyc_wait(LAT + 2);
      log_q.delete();
      req(32'h24, 0, `MEM_COUNT_WORD, 0, 0);
      req(32'h28, 0, `MEM_COUNT_WORD, 0, 0);
      reset = 1; cyc_wait(2); reset = 0;
      cyc_wait(5);
      check("inflight_dropped", log_q.size(), 0);
      wait_ready(0);

      // Random traffic, checked every cycle against the model.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 9) < 3) cyc_wait(1);
         else req($urandom_range(0, WC + 3) * 4 + $urandom_range(0, 3), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cyc_wait(LAT + 3);
      check("drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
